rle_playback_ctrl: RTL

Sequences run-length-encoded video tokens onto the raster produced by the VGA timing generator. It owns the token stream handshake toward the flash/RLE decoder front end and tells that front end when to (re)start a stream. It expands each (run, colour) token into pixels on active cycles and supervises frame alignment and underflow. It sits between the token source and the colour output pins, clocked at the pixel clock.

---
 rtl/rle_playback_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rle_playback_ctrl.sv
// rle_playback_ctrl
// Expands (run, colour) tokens from the RLE decoder front end onto the VGA raster.
// Holds one run in play plus a one-deep look-ahead token so that back-to-back
// single-pixel tokens play without gaps. Watches vsync for frame alignment and
// requests a stream restart after an underflow or a mid-run vsync.
module rle_playback_ctrl #(
  parameter int unsigned RUN_BITS    = 10,
  parameter int unsigned COLOUR_BITS = 6,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   blank,
  input  logic                   vsync_pulse,
  input  logic                   token_valid,
  input  logic [RUN_BITS-1:0]    token_run,
  input  logic [COLOUR_BITS-1:0] token_colour,
  output logic                   token_ready,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   fetch_start,
  output logic                   err_underflow,
  output logic                   err_desync,
  output logic [FRAME_BITS-1:0]  frame_count
);

  // cur_left needs one extra bit: a run of 2^RUN_BITS pixels is representable
  localparam int unsigned LeftBits = RUN_BITS + 1;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StHalt
  } state_e;

  state_e                 r_state;

  // Run currently on screen; r_cur_left == 0 means no run loaded
  logic [COLOUR_BITS-1:0] r_cur_colour;
  logic [LeftBits-1:0]    r_cur_left;

  // Look-ahead token
  logic                   r_nxt_valid;
  logic [RUN_BITS-1:0]    r_nxt_run;
  logic [COLOUR_BITS-1:0] r_nxt_colour;

  logic [COLOUR_BITS-1:0] r_colour;
  logic                   r_fetch_start;
  logic                   r_err_underflow;
  logic                   r_err_desync;
  logic [FRAME_BITS-1:0]  r_frame_count;

  logic                   w_pixel;
  logic                   w_play;
  logic                   w_cur_empty;
  logic                   w_cur_last;
  logic                   w_promote;
  logic                   w_accept;
  logic [LeftBits-1:0]    w_nxt_len;

  // vsync on an unblanked cycle is still treated as a non-displayed pixel
  assign w_pixel     = !blank && !vsync_pulse;
  assign w_play      = (r_state == StPlay);
  assign w_cur_empty = (r_cur_left == '0);
  assign w_cur_last  = (r_cur_left == LeftBits'(1));
  assign w_nxt_len   = {1'b0, r_nxt_run} + LeftBits'(1);

  // Look-ahead moves into the current run when the run is empty or ends on this pixel
  assign w_promote   = w_play && r_nxt_valid && (w_cur_empty || (w_pixel && w_cur_last));

  // Look-ahead slot is free if empty or being vacated this cycle; frozen during vsync
  assign token_ready = w_play && !vsync_pulse && (!r_nxt_valid || w_promote);
  assign w_accept    = token_valid && token_ready;

  assign colour        = r_colour;
  assign fetch_start   = r_fetch_start;
  assign err_underflow = r_err_underflow;
  assign err_desync    = r_err_desync;
  assign frame_count   = r_frame_count;

  // Playback FSM: run/look-ahead storage, pixel output, restart and error supervision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StIdle;
      r_cur_colour    <= '0;
      r_cur_left      <= '0;
      r_nxt_valid     <= 1'b0;
      r_nxt_run       <= '0;
      r_nxt_colour    <= '0;
      r_colour        <= '0;
      r_fetch_start   <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_desync    <= 1'b0;
      r_frame_count   <= '0;
    end else begin
      r_fetch_start <= 1'b0;
      r_colour      <= '0;
      unique case (r_state)
        StIdle, StHalt: begin
          if (vsync_pulse) begin
            r_state       <= StPlay;
            r_fetch_start <= 1'b1;
            r_cur_left    <= '0;
            r_nxt_valid   <= 1'b0;
          end
        end
        StPlay: begin
          if (vsync_pulse) begin
            if (w_cur_empty) begin
              // Clean frame boundary; the look-ahead survives into the new frame
              r_frame_count <= r_frame_count + FRAME_BITS'(1);
              if (w_promote) begin
                r_cur_colour <= r_nxt_colour;
                r_cur_left   <= w_nxt_len;
                r_nxt_valid  <= 1'b0;
              end
            end else begin
              // Stream and raster disagree: drop everything and restart the source
              r_err_desync  <= 1'b1;
              r_cur_left    <= '0;
              r_nxt_valid   <= 1'b0;
              r_fetch_start <= 1'b1;
            end
          end else begin
            if (w_accept) begin
              r_nxt_valid  <= 1'b1;
              r_nxt_run    <= token_run;
              r_nxt_colour <= token_colour;
            end else if (w_promote) begin
              r_nxt_valid <= 1'b0;
            end

            if (w_promote) begin
              r_cur_colour <= r_nxt_colour;
              r_cur_left   <= w_nxt_len;
            end

            if (w_pixel) begin
              if (!w_cur_empty) begin
                r_colour <= r_cur_colour;
                if (!w_cur_last) begin
                  r_cur_left <= r_cur_left - LeftBits'(1);
                end else if (!w_promote) begin
                  r_cur_left <= '0;
                end
              end else if (!r_nxt_valid) begin
                r_err_underflow <= 1'b1;
                r_state         <= StHalt;
              end
              // Empty run with a freshly arrived look-ahead: pixel shows 0 while it loads
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
